// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths and 3-bit ALU control encodings.
// Used by the ID/EX stage and by the execute-stage ALU.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_OR   = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b111;

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle between decode, the bypass sources and the ID/EX stage.
// Handshake: a transfer on either side happens on a rising edge where
// valid and ready are both 1; valid never waits on ready, while id_ready
// may depend combinationally on the offered id_rs1/id_rs2 (hazard check).
interface id_ex_if #(
  parameter int XLEN = cpu_pkg::XLEN,
  parameter int RA_W = cpu_pkg::RA_W
);

  // Decode side
  logic            id_valid;
  logic            id_ready;
  logic [RA_W-1:0] id_rs1;
  logic [RA_W-1:0] id_rs2;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic            id_use_imm;
  logic [2:0]      id_alu_ctrl;
  logic [RA_W-1:0] id_rd;
  logic            id_reg_write;
  logic            id_mem_read;
  logic            flush;

  // Bypass sources from later stages
  logic [RA_W-1:0] exm_rd;
  logic [RA_W-1:0] wb_rd;
  logic            exm_reg_write;
  logic            wb_reg_write;
  logic [XLEN-1:0] exm_result;
  logic [XLEN-1:0] wb_data;

  // Execute side
  logic            ex_ready;
  logic            ex_valid;
  logic [XLEN-1:0] ex_a;
  logic [XLEN-1:0] ex_b;
  logic [2:0]      ex_ctrl;
  logic [XLEN-1:0] ex_store_data;
  logic [RA_W-1:0] ex_rd;
  logic            ex_reg_write;
  logic            ex_mem_read;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_data, id_rs2_data, id_imm,
           id_use_imm, id_alu_ctrl, id_rd, id_reg_write, id_mem_read, flush,
           exm_rd, wb_rd, exm_reg_write, wb_reg_write, exm_result, wb_data,
           ex_ready,
    input  id_ready, ex_valid, ex_a, ex_b, ex_ctrl, ex_store_data, ex_rd,
           ex_reg_write, ex_mem_read
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_data, id_rs2_data, id_imm,
           id_use_imm, id_alu_ctrl, id_rd, id_reg_write, id_mem_read, flush,
           exm_rd, wb_rd, exm_reg_write, wb_reg_write, exm_result, wb_data,
           ex_ready,
    output id_ready, ex_valid, ex_a, ex_b, ex_ctrl, ex_store_data, ex_rd,
           ex_reg_write, ex_mem_read
  );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// One operand forward-select path. With ID_EX_FORWARD_EN defined, EX/MEM
// wins over MEM/WB and x0 is never forwarded; otherwise the latched
// register-file value passes straight through.
module fwd_mux #(
  parameter int XLEN = cpu_pkg::XLEN,
  parameter int RA_W = cpu_pkg::RA_W
) (
  input  logic [RA_W-1:0] rs_i,
  input  logic [XLEN-1:0] rf_data_i,
  input  logic [RA_W-1:0] exm_rd_i,
  input  logic            exm_reg_write_i,
  input  logic [XLEN-1:0] exm_result_i,
  input  logic [RA_W-1:0] wb_rd_i,
  input  logic            wb_reg_write_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic [XLEN-1:0] data_o
);

`ifdef ID_EX_FORWARD_EN
  // Youngest producer first; x0 always reads the latched (zero) value
  always_comb begin
    data_o = rf_data_i;
    if (rs_i != '0) begin
      if (exm_reg_write_i && (exm_rd_i == rs_i)) begin
        data_o = exm_result_i;
      end else if (wb_reg_write_i && (wb_rd_i == rs_i)) begin
        data_o = wb_data_i;
      end
    end
  end
`else
  assign data_o = rf_data_i;

  // Bypass inputs are deliberately ignored in this build
  logic unused_fwd;
  assign unused_fwd = ^{rs_i, exm_rd_i, exm_reg_write_i, exm_result_i,
                        wb_rd_i, wb_reg_write_i, wb_data_i};
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the execute ALU: latches decoded
// operands/control, forwards operands, stalls on hazards, inserts bubbles,
// honours backpressure and branch flush.
// Build option: ID_EX_FORWARD_EN enables EX/MEM and MEM/WB forwarding;
// without it every RAW dependency on an in-flight producer stalls.
module id_ex_stage #(
  parameter int XLEN = cpu_pkg::XLEN,
  parameter int RA_W = cpu_pkg::RA_W
) (
  input  logic     clk,
  input  logic     rst,
  id_ex_if.slave   bus
);

  logic            valid_q,     valid_d;
  logic [RA_W-1:0] rs1_q,       rs1_d;
  logic [RA_W-1:0] rs2_q,       rs2_d;
  logic [XLEN-1:0] rs1_data_q,  rs1_data_d;
  logic [XLEN-1:0] rs2_data_q,  rs2_data_d;
  logic [XLEN-1:0] imm_q,       imm_d;
  logic            use_imm_q,   use_imm_d;
  logic [2:0]      ctrl_q,      ctrl_d;
  logic [RA_W-1:0] rd_q,        rd_d;
  logic            reg_write_q, reg_write_d;
  logic            mem_read_q,  mem_read_d;

  logic            hazard;
  logic            ready;
  logic            accept;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  logic            load_use;
  assign load_use = valid_q && mem_read_q && (rd_q != '0) &&
                    ((rd_q == bus.id_rs1) || (rd_q == bus.id_rs2));

`ifdef ID_EX_FORWARD_EN
  assign hazard = load_use;
`else
  // Without bypassing, any in-flight writer of a source register stalls
  logic raw_rs1, raw_rs2;
  always_comb begin
    raw_rs1 = (bus.id_rs1 != '0) &&
              ((valid_q && reg_write_q && (rd_q == bus.id_rs1)) ||
               (bus.exm_reg_write && (bus.exm_rd == bus.id_rs1)) ||
               (bus.wb_reg_write && (bus.wb_rd == bus.id_rs1)));
    raw_rs2 = (bus.id_rs2 != '0) &&
              ((valid_q && reg_write_q && (rd_q == bus.id_rs2)) ||
               (bus.exm_reg_write && (bus.exm_rd == bus.id_rs2)) ||
               (bus.wb_reg_write && (bus.wb_rd == bus.id_rs2)));
  end
  assign hazard = load_use || raw_rs1 || raw_rs2;
`endif

  assign ready  = (!valid_q || bus.ex_ready) && !hazard && !bus.flush;
  assign accept = bus.id_valid && ready;

  // Next-state: flush kills, accept loads, consume-without-refill bubbles
  always_comb begin
    valid_d     = valid_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    use_imm_d   = use_imm_q;
    ctrl_d      = ctrl_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d     = 1'b1;
      rs1_d       = bus.id_rs1;
      rs2_d       = bus.id_rs2;
      rs1_data_d  = bus.id_rs1_data;
      rs2_data_d  = bus.id_rs2_data;
      imm_d       = bus.id_imm;
      use_imm_d   = bus.id_use_imm;
      ctrl_d      = bus.id_alu_ctrl;
      rd_d        = bus.id_rd;
      reg_write_d = bus.id_reg_write;
      mem_read_d  = bus.id_mem_read;
    end else if (bus.ex_ready && valid_q) begin
      valid_d = 1'b0;
    end
  end

  // Pipeline register with immediate clear on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      use_imm_q   <= 1'b0;
      ctrl_q      <= 3'b000;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      use_imm_q   <= use_imm_d;
      ctrl_q      <= ctrl_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
    end
  end

  fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
    .rs_i            (rs1_q),
    .rf_data_i       (rs1_data_q),
    .exm_rd_i        (bus.exm_rd),
    .exm_reg_write_i (bus.exm_reg_write),
    .exm_result_i    (bus.exm_result),
    .wb_rd_i         (bus.wb_rd),
    .wb_reg_write_i  (bus.wb_reg_write),
    .wb_data_i       (bus.wb_data),
    .data_o          (fwd_rs1)
  );

  fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
    .rs_i            (rs2_q),
    .rf_data_i       (rs2_data_q),
    .exm_rd_i        (bus.exm_rd),
    .exm_reg_write_i (bus.exm_reg_write),
    .exm_result_i    (bus.exm_result),
    .wb_rd_i         (bus.wb_rd),
    .wb_reg_write_i  (bus.wb_reg_write),
    .wb_data_i       (bus.wb_data),
    .data_o          (fwd_rs2)
  );

  assign bus.id_ready      = ready;
  assign bus.ex_valid      = valid_q;
  assign bus.ex_a          = fwd_rs1;
  assign bus.ex_b          = use_imm_q ? imm_q : fwd_rs2;
  assign bus.ex_store_data = fwd_rs2;
  assign bus.ex_ctrl       = ctrl_q;
  assign bus.ex_rd         = rd_q;
  assign bus.ex_reg_write  = valid_q && reg_write_q;
  assign bus.ex_mem_read   = valid_q && mem_read_q;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register sitting directly upstream of the execute-stage ALU.
- Latches decoded operands and control from decode, then drives the ALU's a, b and 3-bit control.
- Applies EX/MEM and MEM/WB operand forwarding, detects load-use hazards and inserts bubbles.
- Handles valid/ready backpressure and branch flush.

Parameters:
XLEN, 32, datapath width (ALU operand width).
RA_W, 5, register address width.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
id_valid  in  1  decode presents an instruction.
id_ready  out  1  stage accepts this cycle.
id_rs1, id_rs2  in  RA_W  source register numbers.
id_rs1_data, id_rs2_data  in  XLEN  register-file read data.
id_imm  in  XLEN  immediate.
id_use_imm  in  1  ALU b takes immediate.
id_alu_ctrl  in  3  ALU op: 000 add, 001 sub, 010 slt, 011 sltu, 100 xor, 110 or, 111 and.
id_rd  in  RA_W  destination register.
id_reg_write  in  1  writes rd.
id_mem_read  in  1  instruction is a load.
flush  in  1  branch redirect; kill stage contents.
exm_rd, wb_rd  in  RA_W  destinations in EX/MEM and MEM/WB.
exm_reg_write, wb_reg_write  in  1  those stages write rd.
exm_result, wb_data  in  XLEN  forwardable values.
ex_ready  in  1  downstream consumes the entry.
ex_valid  out  1  entry valid.
ex_a, ex_b  out  XLEN  ALU operands.
ex_ctrl  out  3  ALU control.
ex_store_data  out  XLEN  forwarded rs2, for stores.
ex_rd  out  RA_W  registered destination.
ex_reg_write, ex_mem_read  out  1  registered flags, gated by ex_valid.

Behaviour:
- Reset (async, immediate): every register clears to 0, so ex_valid=0, ex_ctrl=000, ex_rd=0, ex_reg_write=0, ex_mem_read=0.
- During reset, ex_a, ex_b and ex_store_data show the forwarded value of cleared fields. With rs=0 this is 0.
- Latency: one cycle from accept to ex_valid. Forwarding is combinational on the registered rs fields.
- Hazard (load-use): ex_valid & ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2). Both sources are always compared (conservative).
- id_ready = (!ex_valid | ex_ready) & !hazard & !flush.
- Accept when id_valid & id_ready: load all fields; ex_valid<=1.
- Consumed but not refilled (ex_ready & ex_valid, no accept): ex_valid<=0. This is the bubble, and is the only transition out of the hazard.
- Backpressure (ex_ready=0 with valid entry): all registers hold; outputs stable except the forwarding-driven operands.
- Flush has top priority: ex_valid<=0 next edge, regardless of accept or ex_ready. The simultaneous id instruction is dropped, not held.
- Forward select, per source rs:
  - If rs==0, use latched regfile data.
  - Else if exm_reg_write & exm_rd==rs, use exm_result.
  - Else if wb_reg_write & wb_rd==rs, use wb_data.
  - Else use latched data.
- ex_a = fwd(rs1).
- ex_b = use_imm ? imm : fwd(rs2).
- ex_store_data = fwd(rs2).
- Load timing: one bubble places the load in MEM/WB when the consumer is in this stage, so wb_data supplies load data.
- Widths: all operand paths are XLEN. No arithmetic in this block.

Optional Feature:
ID_EX_FORWARD_EN.
- Defined: forwarding as above; hazard is load-use only.
- Undefined: fwd(rs) is always latched data. The hazard term extends to any rs!=0 matching ex_rd (with ex_reg_write), exm_rd (with exm_reg_write) or wb_rd (with wb_reg_write). The stage stalls until the producer retires.

Decomposition:
- Package cpu_pkg holds XLEN, RA_W, and the ALU control constants ALU_ADD..ALU_AND (000, 001, 010, 011, 100, 110, 111). The ALU shares the same package.
- Sub-module fwd_mux: one forward-select path, instanced for rs1 and rs2.

Test Plan:
- Load add (rs1=1, data 5) → next cycle ex_valid=1, ex_a=5. Assert rst mid-cycle → ex_valid=0 immediately.
- Entry rs1=5; exm_rd=5, exm_reg_write=1, exm_result=0x11; wb_rd=5, wb_data=0x22 → ex_a=0x11. Drop exm_reg_write → ex_a=0x22.
- rs1=0; exm_rd=0, exm_reg_write=1, exm_result=0xFF → ex_a=0.
- Stage holds lw rd=7; id offers add rs2=7 → id_ready=0 one cycle, bubble (ex_valid=0), then accepted; ex_b=wb_data 0x1234.
- ex_ready=0 for 3 cycles with valid entry, id_valid=1 → id_ready=0, ex_ctrl/ex_rd stable, no overwrite.
- flush=1 with id_valid=1 and id_ready-eligible → next cycle ex_valid=0, ex_reg_write=0.
